// File: rtl/conv_window_3_3.sv
// conv_window_3_3: streaming 3x3 window generator with two line buffers feeding a packed patch output
module conv_window_3_3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   PIX_IN,
    input  logic                PIX_VALID,
    output logic [9*DATA_W-1:0] PATCH,
    output logic                PATCH_VALID,
    output logic                FRAME_DONE,
    output logic [CW-1:0]       COL,
    output logic [RW-1:0]       ROW
);
    logic [DATA_W-1:0]            r_lb0 [IMG_W];
    logic [DATA_W-1:0]            r_lb1 [IMG_W];
    logic [0:2][0:2][DATA_W-1:0]  r_win;
    logic [0:2][0:2][DATA_W-1:0]  w_win;
    logic [0:2][DATA_W-1:0]       w_col;
    logic                         w_eol;
    logic                         w_last;
    logic                         w_emit;
    // next window: shift left one column and append {row r-2, row r-1, incoming} at the right
    always_comb begin
        w_col  = {r_lb0[COL], r_lb1[COL], PIX_IN};
        for (int i = 0; i < 3; i++)
            w_win[i] = {r_win[i][1], r_win[i][2], w_col[i]};
        w_eol  = COL == CW'(IMG_W - 1);
        w_last = w_eol && ROW == RW'(IMG_H - 1);
        w_emit = ROW >= RW'(2) && COL >= CW'(2);
    end
    // line buffers are plain RAM: read old contents, then shift the column down one row
    always_ff @(posedge CLK) begin
        if (PIX_VALID) begin
            r_lb0[COL] <= r_lb1[COL];
            r_lb1[COL] <= PIX_IN;
        end
    end
    // counters, window registers and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            COL         <= '0;
            ROW         <= '0;
            PATCH       <= '0;
            PATCH_VALID <= 1'b0;
            FRAME_DONE  <= 1'b0;
            r_win       <= '0;
        end else begin
            PATCH_VALID <= PIX_VALID && w_emit;
            FRAME_DONE  <= PIX_VALID && w_last;
            if (PIX_VALID) begin
                r_win <= w_win;
                COL   <= w_eol ? '0 : COL + 1'b1;
                ROW   <= w_last ? '0 : w_eol ? ROW + 1'b1 : ROW;
                if (w_emit)
                    PATCH <= w_win;
            end
        end
    end
endmodule

// File: doc/conv_window_3_3.md
Name: conv_window_3_3

Overview:
Streaming 3x3 window generator directly upstream of the 3x3 convolution stage. It accepts a raster-order pixel stream, one 16-bit pixel per accepted beat. It keeps two line buffers plus a 3x3 register window, and emits a packed 9-pixel PATCH, bus-compatible with the convolution stage's PATCH input, for every valid (unpadded) window position. It also pulses an end-of-frame marker so downstream can count results per feature map.

Parameters:
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in pixels (>=3)
DATA_W, 16, pixel width in bits

Ports:
CLK  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
PIX_IN  input  DATA_W  incoming pixel, raster order (row-major, left to right)
PIX_VALID  input  1  PIX_IN accepted on any rising edge where high; no backpressure
PATCH  output  9*DATA_W  packed window; [9*DATA_W-1 -: DATA_W] = top-left ... [DATA_W-1:0] = bottom-right, row-major
PATCH_VALID  output  1  one-cycle strobe, PATCH holds a new window
FRAME_DONE  output  1  one-cycle strobe after the last pixel of a frame is accepted
COL  output  clog2(IMG_W)  column counter of next expected pixel (debug)
ROW  output  clog2(IMG_H)  row counter of next expected pixel (debug)

Behaviour:
- Reset (async, rst_n=0): COL=0, ROW=0, PATCH=0, PATCH_VALID=0, FRAME_DONE=0, window regs=0. Line-buffer RAM contents are not cleared; output gating makes them irrelevant.
- Line buffers: two depth-IMG_W shift/circular buffers. LB1 holds row r-1 and LB0 holds row r-2, relative to the current row r. On each accepted pixel at column c:
  - read LB0[c] and LB1[c];
  - write LB0[c]<=LB1[c] and LB1[c]<=PIX_IN.
  - Read-before-write within the same edge.
- Window: 3 rows x 3 columns of registers. On each accept, shift left by one column and load new right column = {LB0[c], LB1[c], PIX_IN} (top, mid, bottom).
- Counters: on accept, COL increments. At COL==IMG_W-1, COL wraps to 0 and ROW increments. At the last pixel (ROW==IMG_H-1, COL==IMG_W-1), both wrap to 0.
- Output rule: PATCH_VALID=1 on the edge after accepting a pixel with ROW>=2 and COL>=2 (sampled pre-increment). Latency 1 cycle. PATCH updates only when PATCH_VALID is asserted and otherwise holds its value.
- Window columns spanning a row wrap (COL 0,1) are never emitted. No padding; (IMG_W-2)*(IMG_H-2) patches per frame.
- FRAME_DONE=1 on the edge after accepting the last pixel of a frame. It coincides with the final PATCH_VALID.
- PIX_VALID low: no state change. PATCH_VALID and FRAME_DONE drop to 0 next edge. Gaps of any length are allowed mid-row.
- Back-to-back frames: the first pixel of frame n+1 may be accepted on the edge right after the last pixel of frame n. Stale rows from frame n are never emitted, because ROW<2 gates output.
- Reset mid-frame: counters return to 0 immediately. The next accepted pixel is treated as pixel (0,0) of a new frame.
- Arithmetic: counters are unsigned and width-sized for the parameters. No pixel arithmetic; data passes bit-exact.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 1..16 continuous. Required outputs, PATCH listed top-left first:
  - edge after pixel 11: 1,2,3,5,6,7,9,10,11;
  - after 12: 2,3,4,6,7,8,10,11,12;
  - after 15: 5,6,7,9,10,11,13,14,15;
  - after 16: 6,7,8,10,11,12,14,15,16, with FRAME_DONE=1 the same cycle.
  - Exactly 4 PATCH_VALID strobes in total.
- Same frame with PIX_VALID low for 3 cycles between every pixel -> identical 4 patches in the same order. PATCH_VALID and FRAME_DONE are each exactly 1 cycle wide; PATCH is stable during gaps.
- Two frames back-to-back (1..16, then 101..116) -> the 5th patch is 101,102,103,105,106,107,109,110,111. No strobe occurs between the frame-2 starts of pixels 101 and 110.
- Assert rst_n=0 asynchronously mid-cycle after pixel 7, then stream 201..216 -> outputs and counters are 0 during reset. First patch is 201,202,203,205,206,207,209,210,211.
- IMG_W=28, IMG_H=28, pixels = (row*28+col) mod 65536 -> 676 patches and one FRAME_DONE. Every patch matches the software 3x3 extraction. The last patch centre is pixel 754 (row 26, col 26).
